// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall sequencer, branch flush, memory freeze and hazard statistics
module hazard_ctrl_unit #(
  parameter int REG_W             = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 4,
  parameter int STAT_W            = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_ex_mem_read_i,
  input  logic [REG_W-1:0]  id_ex_rd_i,
  input  logic [REG_W-1:0]  if_id_rs1_i,
  input  logic [REG_W-1:0]  if_id_rs2_i,
  input  logic              if_id_uses_rs1_i,
  input  logic              if_id_uses_rs2_i,
  input  logic              ex_branch_taken_i,
  input  logic              mem_busy_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              id_ex_bubble_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_write_o,
  output logic [STAT_W-1:0] load_stall_cnt_o,
  output logic [STAT_W-1:0] flush_cnt_o
);
  typedef enum logic {RUN, LOAD_STALL} state_e;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAT_W-1:0] ls_q, ls_d, fl_q, fl_d;
  logic              hz, stall, adv;
  assign hz = id_ex_mem_read_i & (id_ex_rd_i != '0) &
              ((if_id_uses_rs1_i & (if_id_rs1_i == id_ex_rd_i)) |
               (if_id_uses_rs2_i & (if_id_rs2_i == id_ex_rd_i)));
  assign stall = (state_q == LOAD_STALL) | hz;
  // State, stall counter and statistics; async reset returns to RUN with cleared counters
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ls_q    <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ls_q    <= ls_d;
      fl_q    <= fl_d;
    end
  end
  // Next state: freeze holds everything, a taken branch aborts any stall as wrong-path
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ls_d    = ls_q;
    fl_d    = fl_q;
    if (!mem_busy_i) begin
      if (ex_branch_taken_i) begin
        state_d = RUN;
        cnt_d   = '0;
        fl_d    = (&fl_q) ? fl_q : fl_q + STAT_W'(1);
      end else if (state_q == LOAD_STALL) begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? RUN : LOAD_STALL;
      end else if (hz) begin
        ls_d = (&ls_q) ? ls_q : ls_q + STAT_W'(1);
        if (LOAD_STALL_CYCLES > 1) begin
          state_d = LOAD_STALL;
          cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
        end
      end
    end
  end
  assign adv = ~mem_busy_i & (ex_branch_taken_i | ~stall);
  // Pipeline controls: reset forces free-running enables, freeze drops every enable
  always_comb begin
    pc_write_o     = reset_i | adv;
    if_id_write_o  = reset_i | adv;
    ex_mem_write_o = reset_i | ~mem_busy_i;
    id_ex_bubble_o = ~reset_i & ~mem_busy_i & ~ex_branch_taken_i & stall;
    if_id_flush_o  = ~reset_i & ~mem_busy_i & ex_branch_taken_i;
    id_ex_flush_o  = ~reset_i & ~mem_busy_i & ex_branch_taken_i;
  end
  assign load_stall_cnt_o = ls_q;
  assign flush_cnt_o      = fl_q;
endmodule
